// File: rtl/conv_feeder.sv
// conv_feeder: builds a sliding sample window per kernel frame and presents it on a valid/ready port.
package Conv;
  parameter int LEN = 4;
  parameter int WIDTH = 16;
  typedef logic [LEN-1:0][WIDTH-1:0] data_vector;
endpackage

module conv_feeder (
  input  logic                   clk,
  input  logic                   rst,
  input  Conv::data_vector       kernel_in,
  input  logic                   kernel_valid,
  output logic                   kernel_ready,
  input  logic [Conv::WIDTH-1:0] sample,
  input  logic                   sample_last,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output Conv::data_vector       kernel,
  output Conv::data_vector       data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   short_frame
);
  localparam int CW = $clog2(Conv::LEN + 1);
  typedef enum logic [1:0] {LOAD_K, FILL, EMIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic last_flag, k_hs, s_hs, o_hs, full;
  assign k_hs = kernel_valid & kernel_ready;
  assign s_hs = sample_valid & sample_ready;
  assign o_hs = out_valid & out_ready;
  assign full = count == CW'(Conv::LEN - 1);
  // rst gates the handshake outputs so a pending window vanishes in the reset cycle itself
  always_comb begin
    kernel_ready = ~rst & (state == LOAD_K);
    out_valid = ~rst & (state == EMIT);
    sample_ready = ~rst & ((state == FILL) | ((state == EMIT) & out_ready & ~last_flag));
  end
  always_comb begin
    state_n = state;
    case (state)
      LOAD_K: state_n = k_hs ? FILL : LOAD_K;
      FILL: state_n = !s_hs ? FILL : full ? EMIT : sample_last ? LOAD_K : FILL;
      EMIT: state_n = !o_hs ? EMIT : last_flag ? LOAD_K : s_hs ? EMIT : FILL;
      default: state_n = LOAD_K;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_K;
      count <= '0;
      last_flag <= 1'b0;
      kernel <= '0;
      data <= '0;
      short_frame <= 1'b0;
    end else begin
      state <= state_n;
      short_frame <= (state == FILL) & s_hs & ~full & sample_last;
      if (s_hs) data <= {sample, data[Conv::LEN-1:1]};
      if (state == LOAD_K && k_hs) begin
        kernel <= kernel_in;
        count <= '0;
        last_flag <= 1'b0;
      end
      if (state == FILL && s_hs) begin
        count <= full ? count + CW'(1) : sample_last ? '0 : count + CW'(1);
        if (full) last_flag <= sample_last;
      end
      // a window taken without a new sample drops back to FILL one sample short of full
      if (state == EMIT && o_hs) begin
        if (last_flag) begin
          count <= '0;
          last_flag <= 1'b0;
        end else if (s_hs) last_flag <= sample_last;
        else count <= CW'(Conv::LEN - 1);
      end
    end
  end
endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: scoreboard bench; expected windows come from slicing each frame's sample list.
module tb_conv_feeder;
  localparam int L = Conv::LEN;
  typedef Conv::data_vector dv_t;
  typedef struct {dv_t k; dv_t w;} exp_t;

  logic clk = 0, rst = 1;
  dv_t kernel_in = '0, kernel, data;
  logic kernel_valid = 0, kernel_ready;
  logic [Conv::WIDTH-1:0] sample = '0;
  logic sample_last = 0, sample_valid = 0, sample_ready;
  logic out_valid, out_ready, short_frame;

  exp_t q[$];
  int pop_cyc[$];
  int checks = 0, errors = 0, exp_short = 0, got_short = 0, cyc = 0, or_mode = 1;
  logic prev_short = 0;

  conv_feeder dut (
    .clk(clk), .rst(rst), .kernel_in(kernel_in), .kernel_valid(kernel_valid),
    .kernel_ready(kernel_ready), .sample(sample), .sample_last(sample_last),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .kernel(kernel),
    .data(data), .out_valid(out_valid), .out_ready(out_ready), .short_frame(short_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (or_mode == 2) ? 1'($urandom_range(0, 1)) : (or_mode == 1);
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dv_t mk(int s[$], int st);
    dv_t v;
    for (int i = 0; i < L; i++) v[i] = Conv::WIDTH'(s[st + i]);
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected window: got %0h expected none", data);
      end else begin
        e = q.pop_front();
        chk("window data", data, e.w);
        chk("window kernel", kernel, e.k);
      end
      pop_cyc.push_back(cyc);
    end
    if (short_frame) begin
      got_short++;
      chk("short_frame one cycle", prev_short, 0);
    end
    prev_short = short_frame;
  end

  task automatic load_kernel(dv_t k);
    logic hs;
    kernel_in = k;
    kernel_valid = 1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      hs = kernel_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (i >= 200) begin
        chk("kernel handshake timeout", 0, 1);
        break;
      end
    end
    kernel_valid = 0;
  endtask

  task automatic send_sample(int v, logic last);
    logic hs;
    sample = Conv::WIDTH'(v);
    sample_last = last;
    sample_valid = 1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      hs = sample_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (i >= 200) begin
        chk("sample handshake timeout", 0, 1);
        break;
      end
    end
    sample_valid = 0;
    sample_last = 0;
  endtask

  task automatic send_frame(dv_t k, int s[$]);
    exp_t e;
    if (s.size() < L) exp_short++;
    else for (int st = 0; st + L <= s.size(); st++) begin
      e.k = k;
      e.w = mk(s, st);
      q.push_back(e);
    end
    load_kernel(k);
    for (int i = 0; i < s.size(); i++) send_sample(s[i], i == s.size() - 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk);
    chk("queue drained", q.size(), 0);
    @(negedge clk);
    chk("kernel_ready after frame", kernel_ready, 1);
    @(posedge clk);
    #1;
    chk("short_frame count", got_short, exp_short);
  endtask

  task automatic first_frame();
    int k[$] = {1, 2, 3, 4};
    int s[$] = {10, 11, 12, 13};
    pop_cyc.delete();
    send_frame(mk(k, 0), s);
    wait_drain();
    chk("first frame window count", pop_cyc.size(), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k[$], s[$];
    dv_t snap_d, snap_k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset kernel_ready", kernel_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset sample_ready", sample_ready, 0);
    chk("reset short_frame", short_frame, 0);
    chk("reset kernel", kernel, 0);
    chk("reset data", data, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("post-reset kernel_ready", kernel_ready, 1);
    chk("post-reset out_valid", out_valid, 0);
    chk("post-reset sample_ready", sample_ready, 0);
    @(posedge clk);
    #1;
    first_frame();

    k = {5, 6, 7, 8};
    s = {1, 2, 3, 4, 5, 6, 7};
    pop_cyc.delete();
    send_frame(mk(k, 0), s);
    wait_drain();
    chk("stream window count", pop_cyc.size(), 4);
    for (int i = 1; i < pop_cyc.size(); i++) chk("stream no bubble", pop_cyc[i] - pop_cyc[i-1], 1);

    or_mode = 0;
    k = {9, 8, 7, 6};
    s = {20, 21, 22, 23, 24};
    fork
      send_frame(mk(k, 0), s);
      begin
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        chk("stall out_valid", out_valid, 1);
        snap_d = data;
        snap_k = kernel;
        repeat (5) begin
          @(negedge clk);
          chk("stall data", data, mk(s, 0));
          chk("stall kernel", kernel, mk(k, 0));
          chk("stall sample_ready", sample_ready, 0);
          chk("stall out_valid held", out_valid, 1);
        end
        or_mode = 1;
      end
    join
    wait_drain();

    k = {3, 3, 3, 3};
    s = {5, 6};
    send_frame(mk(k, 0), s);
    wait_drain();

    k = {4, 3, 2, 1};
    s = {1, 2, 3, 4, 9};
    q.push_back('{mk(k, 0), mk(s, 0)});
    q.push_back('{mk(k, 0), mk(s, 1)});
    load_kernel(mk(k, 0));
    for (int i = 0; i < 4; i++) send_sample(s[i], 0);
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("gap out_valid", out_valid, 0);
      chk("gap sample_ready", sample_ready, 1);
      @(posedge clk);
      #1;
    end
    send_sample(9, 1);
    wait_drain();

    or_mode = 2;
    for (int f = 0; f < 8; f++) begin
      k.delete();
      s.delete();
      for (int i = 0; i < L; i++) k.push_back($urandom_range(0, 65535));
      for (int i = 0, n = $urandom_range(1, 9); i < n; i++) s.push_back($urandom_range(0, 65535));
      send_frame(mk(k, 0), s);
      wait_drain();
    end

    or_mode = 0;
    k = {7, 7, 7, 7};
    s = {30, 31, 32, 33};
    load_kernel(mk(k, 0));
    for (int i = 0; i < 4; i++) send_sample(s[i], 0);
    @(negedge clk);
    chk("pre-reset out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("reset-cycle out_valid", out_valid, 0);
    chk("reset-cycle kernel_ready", kernel_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid-reset kernel", kernel, 0);
    chk("mid-reset data", data, 0);
    chk("mid-reset out_valid", out_valid, 0);
    or_mode = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    first_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_feeder.md
# conv_feeder

Front-end producer for the convolution operator: accepts a kernel vector and a scalar sample stream, builds a sliding window of the last Conv::LEN samples, and presents each (kernel, window) pair on a valid/ready interface. This block drives the operator's `kernel`/`data`/`in_valid`/`in_ready` port. The operator's `result` port is out of scope. Each frame is: one kernel, then samples up to and including the one marked `sample_last`.

## Interface
- No module parameters. Sizes come from the `Conv` package: `Conv::LEN` (window length, ≥2) and `Conv::WIDTH` (sample width); vectors use `Conv::data_vector`.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `kernel_in` input Conv::data_vector: kernel for the next frame.
- `kernel_valid` input 1 / `kernel_ready` output 1: kernel handshake.
- `sample` input Conv::WIDTH: one input sample.
- `sample_last` input 1: qualifies `sample`; marks the final sample of the frame.
- `sample_valid` input 1 / `sample_ready` output 1: sample handshake.
- `kernel` output Conv::data_vector: registered kernel; connects to the operator's `kernel`.
- `data` output Conv::data_vector: current window; `data[0]` is the oldest sample, `data[LEN-1]` the newest.
- `out_valid` output 1 / `out_ready` input 1: window handshake; connects to the operator's `in_valid`/`in_ready`.
- `short_frame` output 1: one-cycle pulse when a frame ends before a full window exists.

## Operation
- Registers:
  - state ∈ {LOAD_K, FILL, EMIT};
  - count (0..LEN);
  - last_flag;
  - kernel reg;
  - window reg.
- A handshake completes on a rising edge where valid and ready are both 1.
- A shift-in does `data[i] <= data[i+1]` for i < LEN-1 and `data[LEN-1] <= sample`.
- LOAD_K:
  - `kernel_ready`=1, `sample_ready`=0, `out_valid`=0.
  - On kernel handshake: kernel reg <= `kernel_in`; count <= 0; last_flag <= 0; go to FILL.
- FILL:
  - `sample_ready`=1, `out_valid`=0.
  - On sample handshake: shift in; count <= count+1.
  - If count+1 == LEN: go to EMIT, with last_flag <= `sample_last`.
  - Else if `sample_last`=1: pulse `short_frame`, count <= 0, go to LOAD_K. The partial window is discarded and nothing is emitted.
- EMIT:
  - `out_valid`=1.
  - `sample_ready` = `out_ready` & ~last_flag. This is a combinational path from `out_ready`; it is intentional.
  - `kernel` and `data` hold stable while `out_valid`=1 and `out_ready`=0.
- EMIT on window handshake:
  - If last_flag=1: go to LOAD_K; count <= 0; last_flag <= 0.
  - Else if a sample handshake occurs in the same cycle: shift in, stay in EMIT, last_flag <= `sample_last`.
  - Else: count <= LEN-1, go to FILL. The window is kept unchanged; the next accepted sample completes the next window.
- Kernel stays constant for the whole frame. `kernel_ready`=0 outside LOAD_K.
- Window stride is 1. A frame of N ≥ LEN samples yields exactly N−LEN+1 windows.

## Timing
- While `rst`=1, and in the first cycle after it falls:
  - state=LOAD_K, count=0, last_flag=0;
  - kernel and window regs all zero;
  - `out_valid`=0, `short_frame`=0, `sample_ready`=0.
  - `kernel_ready`=0 while `rst`=1, and 1 from the first cycle with `rst`=0.
- Reset mid-frame: everything in flight is discarded with no output. This includes a pending EMIT, which drops `out_valid` in the cycle `rst` is sampled high.
- Latency: the sample handshake that completes a window is at edge t; `out_valid`=1 from t+1 with that window on `data`.
- Throughput: with `out_ready` and `sample_valid` held high, one window per cycle.
- Kernel load costs 1 cycle per frame, plus LEN sample cycles to fill the first window.
- `short_frame` is high for exactly the cycle after the offending edge.

## Test plan
(Bench configured with Conv::LEN=4.)
- Reset and first frame:
  - Stimulus: reset, then load kernel {1,2,3,4}; stream samples 10,11,12,13(last) with `out_ready`=1.
  - Required: exactly one window, `data`={10,11,12,13}, `kernel`={1,2,3,4}. `kernel_ready`=1 the following cycle.
- Streaming:
  - Stimulus: stream samples 1..7 (7 = last) with `sample_valid`=`out_ready`=1 throughout.
  - Required: 4 windows {1..4},{2..5},{3..6},{4..7} on 4 consecutive cycles; no bubbles after the first.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles during EMIT.
  - Required: `data`/`kernel` unchanged and `sample_ready`=0 during the stall. Release yields the same window once; no duplicates, no loss.
- Short frame:
  - Stimulus: kernel, then samples 5,6(last).
  - Required: no `out_valid`; `short_frame` pulses 1 cycle; block returns to LOAD_K.
- Stall gap:
  - Stimulus: after the first window handshake, leave `sample_valid`=0 for 3 cycles, then send 9(last).
  - Required: FILL with `out_valid`=0 during the gap; next window = previous window shifted with 9 at `data[3]`.
- Mid-frame reset:
  - Stimulus: assert `rst` for 1 cycle while `out_valid`=1.
  - Required: `out_valid`=0 in the reset cycle; all regs zero; the next frame behaves as in the first scenario.
